sc_window_accumulator: RTL
==========================

SC_WINDOW_ACCUMULATOR -- requirements
Module: sc_window_accumulator

Interface
REQ-001 SHALL have parameter K, default 3, meaning log2 of lane count.
REQ-002 SHALL have parameter N, default 2**K, meaning stochastic-bitstream lanes per beat.
REQ-003 SHALL have parameter LW, default 2, meaning log2 of window length; window W = 2**LW accepted beats.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, synchronous abort of any window in progress.
REQ-007 SHALL have port start, input, 1, pulse opening a new window.
REQ-008 SHALL have port bipolar, input, 1, output mode (0 unipolar, 1 bipolar), sampled when start is accepted.
REQ-009 SHALL have port in_valid, input, 1, data_in holds a beat.
REQ-010 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-011 SHALL have port data_in, input, N, one bit per lane.
REQ-012 SHALL have port out_valid, output, 1, result is valid.
REQ-013 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-014 SHALL have port result, output, K+LW+2, signed two's-complement window result.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-017 IDLE: start=1 -> ACCUM, sum, beat counter and popcount register cleared, bipolar latched.
REQ-018 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid && in_ready.
REQ-019 Each accepted beat: popcount of data_in (0..N, K+1 bits) registered at that edge; the registered popcount is added to sum (K+LW+1 bits, unsigned) on the following edge.
REQ-020 ACCUM: accepted beat number W -> DRAIN; in_valid gaps SHALL stall without changing sum or beat counter.
REQ-021 DRAIN: one cycle, adds final popcount -> DONE.
REQ-022 out_valid SHALL be 1 exactly in DONE, i.e. from the second edge after the last beat's acceptance edge.
REQ-023 Unipolar: result = zero-extended sum (0..N*W); bipolar: result = 2*sum - N*W (-N*W..+N*W); no overflow possible by width.
REQ-024 result SHALL hold stable while out_valid && !out_ready.
REQ-025 DONE: out_ready=1 -> IDLE; out_ready=1 with start=1 same cycle -> ACCUM with fresh window (back-to-back).
REQ-026 start in ACCUM, DRAIN, or DONE without out_ready SHALL be ignored.
REQ-027 clear=1 SHALL force IDLE and zero sum, counter, popcount register, result in any state; clear wins over simultaneous start, beat, or out_ready.
REQ-028 result SHALL read 0 outside DONE.

Reset
REQ-029 reset_n=0 SHALL asynchronously force IDLE, in_ready=0, out_valid=0, busy=0, result=0, all internal registers 0.
REQ-030 Reset mid-window SHALL discard partial sum; first valid window after release requires a new start.

Structure
REQ-031 State enum and width helper constants (popcount width K+1, sum width K+LW+1, result width K+LW+2) SHALL live in shared package sc_pkg.
REQ-032 Popcount SHALL be a separate combinational sub-module sc_popcount parameterised by N.
REQ-033 Datapath SHALL be one registered popcount stage plus one accumulator register; no other pipelining.

Verification (K=3, LW=2: N=8, W=4)
REQ-034 Unipolar, start then 4 beats 8'hFF back-to-back -> out_valid 2 cycles after 4th acceptance, result=32.
REQ-035 Bipolar, 4 beats 8'h0F -> result=0; bipolar 4 beats 8'h00 -> result=-32.
REQ-036 Unipolar, beats 8'h01 with in_valid idle cycles between -> result=4; beats offered in DONE not accepted (in_ready=0).
REQ-037 out_ready low 5 cycles in DONE -> result/out_valid stable; then out_ready=1 with start=1 -> ACCUM next cycle, in_ready=1, next window 4x 8'h03 -> result=8.
REQ-038 reset_n pulsed low after 2 beats -> outputs 0 immediately (async), IDLE; clear after 2 beats with start same cycle -> IDLE, busy=0.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared state encodings and width helpers for the stochastic-computing
// window accumulator and its popcount stage.
package sc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Popcount of N = 2**k lanes needs k+1 bits (value N itself included).
  function automatic int pc_width(input int k);
    return k + 1;
  endfunction

  function automatic int sum_width(input int k, input int lw);
    return k + lw + 1;
  endfunction

  // One extra bit over the sum so 2*sum - N*W stays representable signed.
  function automatic int res_width(input int k, input int lw);
    return k + lw + 2;
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Purely combinational count of the set bits across N stochastic lanes.
module sc_popcount #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic [N-1:0]  data_in,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(data_in[i]);
    end
  end

endmodule

// File: rtl/sc_window_accumulator.sv
// Accumulates lane popcounts over a window of W accepted beats and reports
// the total as a unipolar count or a bipolar (2*sum - N*W) value.
module sc_window_accumulator
  import sc_pkg::*;
#(
  parameter int K  = 3,
  parameter int N  = 2**K,
  parameter int LW = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      clear,
  input  logic                                      start,
  input  logic                                      bipolar,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [N-1:0]                              data_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic signed [res_width(K, LW)-1:0]        result,
  output logic                                      busy
);

  localparam int PW = pc_width(K);
  localparam int SW = sum_width(K, LW);
  localparam int RW = res_width(K, LW);
  localparam int W  = 2**LW;
  localparam int CW = LW + 1;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          bip_q, bip_d;
  logic [PW-1:0] pc_comb;
  logic [RW-1:0] res_c;
  logic          accept;

  sc_popcount #(
    .N  (N),
    .CW (PW)
  ) u_popcount (
    .data_in (data_in),
    .count   (pc_comb)
  );

  assign accept = (state_q == ST_ACCUM) && in_valid;

  // pc_q is zero whenever no beat was accepted on the previous edge, so the
  // accumulator can add it unconditionally and in_valid gaps add nothing.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    pc_d    = '0;
    bip_d   = bip_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          sum_d   = '0;
          cnt_d   = '0;
          bip_d   = bipolar;
        end
      end
      ST_ACCUM: begin
        sum_d = sum_q + SW'(pc_q);
        if (accept) begin
          pc_d  = pc_comb;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        sum_d   = sum_q + SW'(pc_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (start) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            cnt_d   = '0;
            bip_d   = bipolar;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      pc_d    = '0;
      bip_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      pc_q    <= '0;
      bip_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      bip_q   <= bip_d;
    end
  end

  // Result is only meaningful in DONE; elsewhere it reads as zero.
  always_comb begin
    res_c = '0;
    if (state_q == ST_DONE) begin
      if (bip_q) begin
        res_c = (RW'(sum_q) << 1) - RW'(N * W);
      end else begin
        res_c = RW'(sum_q);
      end
    end
  end

  assign result    = $signed(res_c);
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule
